b_resolve_and_train: RTL and testbench

- Back end of the B-branch perceptron predictor.
- Queues each B prediction issued by fetch and accepts in-order resolutions from execute.
- Detects mispredicts and drives the correct-PC/counter/pending-count signals consumed by fetch prediction.
- Owns and trains the 4-slot x 9-weight perceptron table, exporting it as the 288-bit weight bus.

---
 rtl/bpred_pkg.sv | 40 ++++
 rtl/b_pending_queue.sv | 51 +++++
 rtl/b_resolve_and_train.sv | 138 +++++++++++++
 tb/tb_b_resolve_and_train.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bpred_pkg.sv
// Shared types and constants for the B-branch perceptron back end.
// Covers the resolve FSM states, pending-queue entry layout and saturating weight add.
package bpred_pkg;
    localparam int DEPTH = 8;
    localparam int HIST  = 8;
    localparam int NSLOT = 4;
    localparam int WBITS = 8;
    localparam int THETA = 29;
    localparam int SUMW  = 11;
    localparam int SLOTW = $clog2(NSLOT);
    localparam int PTRW  = $clog2(DEPTH);
    localparam int CNTW  = PTRW + 1;
    localparam int NWGT  = HIST + 1;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        UPDATE,
        UPDATE_FLUSH
    } stateT;

    typedef struct packed {
        logic                   taken;
        logic [SLOTW-1:0]       slot;
        logic [HIST-1:0]        hist;
        logic signed [SUMW-1:0] sum;
        logic [31:0]            target;
        logic [31:0]            fallPc;
    } predEntryT;

    // d is +1 or -1; a result outside [-128, +127] is clamped to the nearer limit
    function automatic logic [WBITS-1:0] sat_add_w(input logic [WBITS-1:0] w, input logic [1:0] d);
        logic [WBITS:0] s;
        s = {w[WBITS-1], w} + {{(WBITS-1){d[1]}}, d};
        if (s[WBITS] != s[WBITS-1])
            sat_add_w = s[WBITS] ? {1'b1, {(WBITS-1){1'b0}}} : {1'b0, {(WBITS-1){1'b1}}};
        else
            sat_add_w = s[WBITS-1:0];
    endfunction
endpackage

// File: rtl/b_pending_queue.sv
// Synchronous FIFO of issued B predictions awaiting resolution.
// Flush wins over push and pop in the same cycle.
module b_pending_queue
    import bpred_pkg::*;
(
    input  logic            clkSys,
    input  logic            rstB,
    input  logic            push,
    input  predEntryT       pushData,
    input  logic            pop,
    input  logic            flush,
    output predEntryT       headData,
    output logic            full,
    output logic            empty,
    output logic [CNTW-1:0] count
);
    predEntryT       mem [DEPTH];
    logic [PTRW-1:0] wrPtr;
    logic [PTRW-1:0] rdPtr;
    logic            doPush;
    logic            doPop;

    assign full     = (count == CNTW'(DEPTH));
    assign empty    = (count == '0);
    assign doPush   = push && !full && !flush;
    assign doPop    = pop && !empty && !flush;
    assign headData = mem[rdPtr];

    always_ff @(posedge clkSys) begin
        if (doPush)
            mem[wrPtr] <= pushData;
    end

    always_ff @(posedge clkSys) begin
        if (!rstB) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush)
                wrPtr <= wrPtr + PTRW'(1);
            if (doPop)
                rdPtr <= rdPtr + PTRW'(1);
            count <= count + CNTW'(doPush) - CNTW'(doPop);
        end
    end
endmodule

// File: rtl/b_resolve_and_train.sv
// Resolve/train back end: queues B predictions, checks in-order resolutions,
// reports mispredicts to fetch and trains the perceptron weight table.
//
// state        | meaning
// IDLE         | waiting for a resolution of the oldest pending B
// CHECK        | compare latched prediction with the actual outcome
// UPDATE       | correct prediction; train weights if low confidence
// UPDATE_FLUSH | mispredict; correct PC out, train, empty the queue
module b_resolve_and_train
    import bpred_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rstn,
    input  logic         i_predValid,
    output logic         o_predReady,
    input  logic         i_predTaken,
    input  logic [1:0]   i_predSlot,
    input  logic [7:0]   i_predHist,
    input  logic [10:0]  i_predSum,
    input  logic [31:0]  i_predTargetPc,
    input  logic [31:0]  i_predFallPc,
    input  logic         i_resValid,
    output logic         o_resReady,
    input  logic         i_resTaken,
    input  logic [31:0]  i_resTarget,
    output logic [31:0]  o_correctPC,
    output logic [2:0]   o_counter_3,
    output logic [7:0]   o_pendingB_8,
    output logic [287:0] o_weights_288
);
    stateT            state;
    stateT            stateNext;
    predEntryT        pushEntry;
    predEntryT        headEntry;
    predEntryT        lat;
    logic             latResTaken;
    logic [31:0]      latResTarget;
    logic             qFull;
    logic             qEmpty;
    logic [CNTW-1:0]  qCount;
    logic             pushFire;
    logic             accept;
    logic             mis;
    logic             train;
    logic [SUMW:0]    sumExt;
    logic [SUMW:0]    sumAbs;
    logic [31:0]      correctPcReg;
    logic [WBITS-1:0] w [NSLOT][NWGT];

    assign pushEntry = '{taken:  i_predTaken,
                         slot:   i_predSlot,
                         hist:   i_predHist,
                         sum:    i_predSum,
                         target: i_predTargetPc,
                         fallPc: i_predFallPc};

    assign accept       = (state == IDLE) && i_resValid && !qEmpty;
    assign o_resReady   = accept;
    assign o_counter_3  = {2'b00, accept};
    assign o_predReady  = !qFull && (state != UPDATE_FLUSH);
    assign pushFire     = i_predValid && o_predReady;
    assign o_pendingB_8 = 8'(qCount);
    assign o_correctPC  = correctPcReg;

    b_pending_queue uQueue (
        .clkSys   (i_clk),
        .rstB     (i_rstn),
        .push     (pushFire),
        .pushData (pushEntry),
        .pop      (accept),
        .flush    (state == UPDATE_FLUSH),
        .headData (headEntry),
        .full     (qFull),
        .empty    (qEmpty),
        .count    (qCount)
    );

    // The latch holds steady from CHECK through UPDATE since accepts only happen in IDLE
    always_ff @(posedge i_clk) begin
        if (accept) begin
            lat          <= headEntry;
            latResTaken  <= i_resTaken;
            latResTarget <= i_resTarget;
        end
    end

    assign mis    = (lat.taken != latResTaken) || (latResTaken && (latResTarget != lat.target));
    assign sumExt = {lat.sum[SUMW-1], lat.sum};
    assign sumAbs = sumExt[SUMW] ? -sumExt : sumExt;
    assign train  = mis || (sumAbs <= (SUMW+1)'(THETA));

    always_ff @(posedge i_clk) begin
        if (!i_rstn)
            state <= IDLE;
        else
            state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:         if (accept) stateNext = CHECK;
            CHECK:        stateNext = mis ? UPDATE_FLUSH : UPDATE;
            UPDATE:       stateNext = IDLE;
            UPDATE_FLUSH: stateNext = IDLE;
            default:      stateNext = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn)
            correctPcReg <= '0;
        else if ((state == CHECK) && mis)
            correctPcReg <= latResTaken ? latResTarget : lat.fallPc;
        else
            correctPcReg <= '0;
    end

    // Each weight moves toward agreement between its history bit and the outcome
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            for (int s = 0; s < NSLOT; s++)
                for (int j = 0; j < NWGT; j++)
                    w[s][j] <= '0;
        end else if (((state == UPDATE) || (state == UPDATE_FLUSH)) && train) begin
            for (int j = 0; j < HIST; j++)
                w[lat.slot][j] <= sat_add_w(w[lat.slot][j], (lat.hist[j] == latResTaken) ? 2'b01 : 2'b11);
            w[lat.slot][HIST] <= sat_add_w(w[lat.slot][HIST], latResTaken ? 2'b01 : 2'b11);
        end
    end

    always_comb begin
        o_weights_288 = '0;
        for (int s = 0; s < NSLOT; s++)
            for (int j = 0; j < NWGT; j++)
                o_weights_288[s*NWGT*WBITS + j*WBITS +: WBITS] = w[s][j];
    end
endmodule

// File: tb/tb_b_resolve_and_train.sv
// Self-checking bench for b_resolve_and_train: cycle-level queue/weight model
// compared every cycle, plus directed literal checks.
module tb_b_resolve_and_train;
    logic         clk = 1'b0;
    logic         rstn;
    logic         predValid;
    logic         predReady;
    logic         predTaken;
    logic [1:0]   predSlot;
    logic [7:0]   predHist;
    logic [10:0]  predSum;
    logic [31:0]  predTargetPc;
    logic [31:0]  predFallPc;
    logic         resValid;
    logic         resReady;
    logic         resTaken;
    logic [31:0]  resTarget;
    logic [31:0]  correctPC;
    logic [2:0]   counter3;
    logic [7:0]   pendingB;
    logic [287:0] weights;

    int nChecks = 0;
    int nFail   = 0;

    always #5 clk = ~clk;

    b_resolve_and_train dut (
        .i_clk          (clk),
        .i_rstn         (rstn),
        .i_predValid    (predValid),
        .o_predReady    (predReady),
        .i_predTaken    (predTaken),
        .i_predSlot     (predSlot),
        .i_predHist     (predHist),
        .i_predSum      (predSum),
        .i_predTargetPc (predTargetPc),
        .i_predFallPc   (predFallPc),
        .i_resValid     (resValid),
        .o_resReady     (resReady),
        .i_resTaken     (resTaken),
        .i_resTarget    (resTarget),
        .o_correctPC    (correctPC),
        .o_counter_3    (counter3),
        .o_pendingB_8   (pendingB),
        .o_weights_288  (weights)
    );

    task automatic chk(input string nm, input logic [287:0] act, input logic [287:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit          taken;
        int          slot;
        logic [7:0]  hist;
        int          sum;
        logic [31:0] target;
        logic [31:0] fallPc;
    } entT;

    entT         mq[$];
    int          wm[4][9];
    int          cyc = 0;
    bit          seenReset = 0;
    bit          hasAcc = 0;
    int          accCyc = 0;
    bit          lMis;
    bit          lTrain;
    bit          lTk;
    logic [31:0] lCorr;
    entT         lE;

    function automatic int sat(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    function automatic logic [287:0] packW();
        logic [287:0] r;
        logic [7:0]   b;
        r = '0;
        for (int s = 0; s < 4; s++)
            for (int j = 0; j < 9; j++) begin
                b = 8'(wm[s][j]);
                r[s*72 + j*8 +: 8] = b;
            end
        return r;
    endfunction

    always @(negedge clk) begin
        bit          busy;
        bit          eRdy;
        bit          eRes;
        bit          pulse;
        logic [31:0] eCorr;
        entT         e;
        int          t;
        int          absSum;
        pulse = hasAcc && (cyc == accCyc + 2);
        busy  = hasAcc && ((cyc == accCyc + 1) || pulse);
        eRdy  = (mq.size() < 8) && !(pulse && lMis);
        eRes  = !busy && resValid && (mq.size() > 0);
        eCorr = (pulse && lMis) ? lCorr : 32'h0;
        if (seenReset) begin
            chk("pendingB",  288'(pendingB),  288'(8'(mq.size())));
            chk("predReady", 288'(predReady), 288'(eRdy));
            chk("resReady",  288'(resReady),  288'(eRes));
            chk("counter",   288'(counter3),  288'({2'b00, eRes}));
            chk("correctPC", 288'(correctPC), 288'(eCorr));
            chk("weights",   weights,         packW());
        end
        if (pulse) begin
            if (lTrain) begin
                t = lTk ? 1 : -1;
                for (int j = 0; j < 8; j++)
                    wm[lE.slot][j] = sat(wm[lE.slot][j] + (lE.hist[j] ? t : -t));
                wm[lE.slot][8] = sat(wm[lE.slot][8] + t);
            end
            if (lMis) mq.delete();
        end
        if (eRes) begin
            lE     = mq.pop_front();
            lTk    = resTaken;
            lMis   = (lE.taken != resTaken) || (resTaken && (resTarget != lE.target));
            absSum = (lE.sum < 0) ? -lE.sum : lE.sum;
            lTrain = lMis || (absSum <= 29);
            lCorr  = resTaken ? resTarget : lE.fallPc;
            accCyc = cyc;
            hasAcc = 1;
        end
        if (predValid && eRdy) begin
            e.taken  = predTaken;
            e.slot   = int'(predSlot);
            e.hist   = predHist;
            e.sum    = int'($signed(predSum));
            e.target = predTargetPc;
            e.fallPc = predFallPc;
            mq.push_back(e);
        end
        if (!rstn) begin
            mq.delete();
            for (int s = 0; s < 4; s++)
                for (int j = 0; j < 9; j++)
                    wm[s][j] = 0;
            hasAcc    = 0;
            seenReset = 1;
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit tk, input logic [1:0] sl, input logic [7:0] h,
                        input logic [10:0] sm, input logic [31:0] tg, input logic [31:0] fp);
        predValid = 1; predTaken = tk; predSlot = sl; predHist = h;
        predSum = sm; predTargetPc = tg; predFallPc = fp;
        tick();
        predValid = 0;
    endtask

    // Returns one cycle after acceptance (the check cycle)
    task automatic resolve(input bit tk, input logic [31:0] tg);
        bit got;
        got = 0;
        resValid = 1; resTaken = tk; resTarget = tg;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            if (resReady) got = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        chk("resAccept", 288'(got), 288'(1'b1));
        if (got) tick();
        resValid = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rstn = 0; predValid = 0; predTaken = 0; predSlot = 0; predHist = 0;
        predSum = 0; predTargetPc = 0; predFallPc = 0;
        resValid = 0; resTaken = 0; resTarget = 0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1;

        // three pushes, nothing resolved yet
        for (int i = 0; i < 3; i++) push(1, 2'd3, 8'hAA, 11'd100, 32'h4000, 32'h8);
        @(negedge clk);
        chk("t1 pending", 288'(pendingB), 288'(8'd3));
        chk("t1 weights", weights, 288'h0);
        chk("t1 predReady", 288'(predReady), 288'(1'b1));
        tick();
        for (int i = 0; i < 3; i++) begin resolve(1, 32'h4000); tick(); tick(); end

        // correct, high confidence: no pulse, no training
        push(1, 2'd0, 8'hFF, 11'd40, 32'h1000, 32'h4);
        resolve(1, 32'h1000);
        @(negedge clk); chk("t2 corrN1", 288'(correctPC), 288'h0); tick();
        @(negedge clk); chk("t2 corrN2", 288'(correctPC), 288'h0); tick();
        @(negedge clk);
        chk("t2 pending", 288'(pendingB), 288'h0);
        chk("t2 weights", weights, 288'h0);
        tick();

        // mispredict with flush and a wrong-path push during the flush cycle
        push(0, 2'd1, 8'h0F, 11'h7FB, 32'h2000, 32'h204);
        push(1, 2'd3, 8'h55, 11'd50, 32'h2100, 32'h208);
        resolve(1, 32'h3000);
        @(negedge clk); chk("t3 corrN1", 288'(correctPC), 288'h0); tick();
        predValid = 1; predTaken = 1; predSlot = 2'd0; predHist = 8'h11;
        predSum = 11'd3; predTargetPc = 32'h9000; predFallPc = 32'h9004;
        @(negedge clk);
        chk("t3 corrN2", 288'(correctPC), 288'(32'h3000));
        chk("t3 readyFlush", 288'(predReady), 288'(1'b0));
        tick();
        predValid = 0;
        @(negedge clk);
        chk("t3 corrN3", 288'(correctPC), 288'h0);
        chk("t3 pending", 288'(pendingB), 288'h0);
        chk("t3 slot1", 288'(weights[72 +: 72]), 288'(72'h01FFFFFFFF01010101));
        tick();

        // fill to 8, ninth push dropped
        for (int i = 0; i < 8; i++) push(1, 2'd3, 8'hAA, 11'd100, 32'h4000, 32'h8);
        predValid = 1;
        @(negedge clk);
        chk("t4 readyFull", 288'(predReady), 288'(1'b0));
        chk("t4 pendingFull", 288'(pendingB), 288'(8'd8));
        tick();
        predValid = 0;
        @(negedge clk); chk("t4 pendingAfter", 288'(pendingB), 288'(8'd8)); tick();
        for (int i = 0; i < 8; i++) begin resolve(1, 32'h4000); tick(); tick(); end

        // drive slot 2 weight 0 to saturation
        for (int k = 0; k < 127; k++) begin
            push(1, 2'd2, 8'h01, 11'd0, 32'h6000, 32'h8);
            resolve(1, 32'h6000); tick(); tick();
        end
        @(negedge clk);
        chk("t5 w0at127", 288'(weights[144 +: 8]), 288'(8'h7F));
        chk("t5 w1atm127", 288'(weights[152 +: 8]), 288'(8'h81));
        tick();
        push(1, 2'd2, 8'h01, 11'd0, 32'h6000, 32'h8);
        resolve(1, 32'h6000); tick(); tick();
        @(negedge clk);
        chk("t5 w0sat", 288'(weights[144 +: 8]), 288'(8'h7F));
        chk("t5 w1sat", 288'(weights[152 +: 8]), 288'(8'h80));
        chk("t5 bias", 288'(weights[208 +: 8]), 288'(8'h7F));
        tick();

        // reset during the check of a mispredict
        push(0, 2'd0, 8'h33, 11'd10, 32'h7000, 32'h300);
        resolve(1, 32'h5000);
        rstn = 0;
        tick();
        rstn = 1;
        @(negedge clk);
        chk("t6 corr", 288'(correctPC), 288'h0);
        chk("t6 weights", weights, 288'h0);
        chk("t6 pending", 288'(pendingB), 288'h0);
        tick();
        @(negedge clk);
        chk("t6 corrNext", 288'(correctPC), 288'h0);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
